// File: rtl/lsu.sv
// Load/store unit: one access at a time against a single-cycle data memory.
// Define LSU_BYTE_EN to add byte loads and read-modify-write byte stores.
module lsu #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rword_q, rword_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic              signed_q, signed_d;
  logic              err_q, err_d;

  logic              byte_in;
  logic              signed_in;
  logic [DATA_W-1:0] store_word;
  logic [DATA_W-1:0] load_word;

`ifdef LSU_BYTE_EN
  logic [7:0] lane;

  assign byte_in   = req_byte;
  assign signed_in = req_signed;
  assign lane      = addr_q[0] ? rword_q[15:8] : rword_q[7:0];
  assign load_word = byte_q ? {{8{signed_q & lane[7]}}, lane} : rword_q;
  // Byte store merges the new byte into the lane of the word just read.
  assign store_word = !byte_q   ? wdata_q :
                      addr_q[0] ? {wdata_q[7:0], rword_q[7:0]} :
                                  {rword_q[15:8], wdata_q[7:0]};
`else
  logic unused_byte_ctl;

  assign byte_in         = 1'b0;
  assign signed_in       = 1'b0;
  assign load_word       = rword_q;
  assign store_word      = wdata_q;
  assign unused_byte_ctl = ^{req_byte, req_signed, byte_q, signed_q};
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rword_d  = rword_q;
    we_d     = we_q;
    byte_d   = byte_q;
    signed_d = signed_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          we_d     = req_we;
          byte_d   = byte_in;
          signed_d = signed_in;
          err_d    = !byte_in && req_addr[0];
          if (!byte_in && req_addr[0]) state_d = RESP;
          else if (!req_we || byte_in) state_d = RD;
          else                         state_d = WR;
        end
      end
      RD: begin
        rword_d = mem_rdata;
        state_d = we_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rword_q  <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rword_q  <= rword_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      signed_q <= signed_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode straight from state so reset clears the strobes at once.
  assign req_ready  = (state_q == IDLE);
  assign mem_read   = (state_q == RD);
  assign mem_write  = (state_q == WR);
  assign mem_addr   = (state_q == RD || state_q == WR) ? addr_q : '0;
  assign mem_wdata  = (state_q == WR) ? store_word : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = (state_q == RESP && !we_q && !err_q) ? load_word : '0;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data-memory word width; only 16 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, core presents an access.
REQ-006 SHALL have port req_ready, output, 1, LSU accepts an access this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_byte, input, 1, 1 = byte access, 0 = word access.
REQ-009 SHALL have port req_signed, input, 1, sign-extend a byte load.
REQ-010 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-011 SHALL have port req_wdata, input, 16, store data; a byte store uses bits [7:0].
REQ-012 SHALL have port resp_valid, output, 1, result available.
REQ-013 SHALL have port resp_ready, input, 1, core consumes the result.
REQ-014 SHALL have port resp_rdata, output, 16, load result; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1, misaligned word access.
REQ-016 SHALL have port mem_addr, output, ADDR_W, to the data memory addr input.
REQ-017 SHALL have port mem_wdata, output, 16, to the data memory write_data input.
REQ-018 SHALL have port mem_write, output, 1, memory write strobe, sampled at the rising edge.
REQ-019 SHALL have port mem_read, output, 1, memory read enable; read_data is combinational.
REQ-020 SHALL have port mem_rdata, input, 16, from the data memory read_data output.

Function
REQ-021 SHALL implement the FSM states IDLE, RD, WR, RESP.
REQ-022 IDLE SHALL drive req_ready=1; every other state SHALL drive req_ready=0.
REQ-023 On req_valid&&req_ready, the LSU SHALL capture addr, wdata, we, byte and signed into registers.
REQ-024 The next state after IDLE SHALL be:
- misaligned word access (!byte && addr[0]) -> RESP, err=1, no memory strobe;
- load -> RD;
- word store -> WR;
- byte store -> RD, for read-modify-write.
REQ-025 RD SHALL assert mem_read=1 for exactly one cycle and register mem_rdata at the end of that cycle.
- From a load, RD SHALL go to RESP.
- From a byte store, RD SHALL go to WR.
REQ-026 WR SHALL assert mem_write=1 for exactly one cycle, then go to RESP.
REQ-027 In WR, mem_wdata SHALL be:
- word store: the captured wdata;
- byte store: the read word with lane addr[0] replaced (addr[0]=0 -> bits [7:0], 1 -> bits [15:8]) by wdata[7:0].
REQ-028 mem_addr SHALL equal the captured address in RD and WR, and 0 otherwise.
REQ-029 Outside RD, mem_read SHALL be 0; outside WR, mem_write and mem_wdata SHALL be 0.
REQ-030 Load result rules:
- word load: the read word;
- byte load: the selected lane, zero-extended, or sign-extended from bit 7 when signed=1.
REQ-031 RESP SHALL hold resp_valid=1 with stable rdata/err until resp_ready=1, then go to IDLE.
- No new request SHALL be accepted in that same cycle.
REQ-032 Latency from accept edge to resp_valid SHALL be:
- misaligned: 1 cycle;
- load or word store: 2 cycles;
- byte store: 3 cycles.
REQ-033 Address wrap SHALL be none; bits above ADDR_W SHALL not exist, and address 0xFFFF byte accesses SHALL be legal.

Reset
REQ-034 While rst_n=0, the LSU SHALL be in state IDLE with all registers 0.
- Outputs: resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, req_ready=1.
REQ-035 Reset asserted mid-access SHALL drop mem_write immediately (asynchronously).
- A partially completed byte store SHALL write nothing if reset is asserted before the WR edge.

Configuration
REQ-036 Macro LSU_BYTE_EN defined: byte accesses and read-modify-write SHALL be implemented per REQ-024..REQ-030.
REQ-037 Macro LSU_BYTE_EN undefined: req_byte and req_signed SHALL be ignored.
- Every access SHALL be a word access.
- Stores SHALL go straight to WR.
- The merge logic SHALL be absent.

Verification
REQ-038 Word store addr 0x0004 wdata 0xBEEF -> one-cycle mem_write with mem_addr 0x0004, mem_wdata 0xBEEF; resp_valid 2 cycles after accept.
REQ-039 Memory word 0x0004 = 0xBEEF, byte store addr 0x0005 wdata 0x0012 -> RD then WR with mem_wdata 0x12EF; resp_valid 3 cycles after accept.
REQ-040 Memory word 0x0004 = 0x80EF, signed byte load addr 0x0005 -> resp_rdata 0xFF80; unsigned -> 0x0080; addr 0x0004 signed -> 0xFFEF.
REQ-041 Word load addr 0x0003 -> resp_err=1, resp_rdata=0, no mem_read/mem_write pulse; resp_valid 1 cycle after accept.
REQ-042 resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0; released -> IDLE next cycle.
REQ-043 rst_n pulsed low during RD of a byte store -> no mem_write pulse, all outputs at reset values, next request serviced normally.
